// File: rtl/mio_pkg.sv
// Shared definitions for the MIO bus slice: Button address decode constants
// (also used by the bus decoder), the default key code width and the access
// FSM state encoding used by the key input buffer.
package mio_pkg;

    localparam int          KEY_W      = 5;
    localparam logic [31:0] BTN_ADDR_1 = 32'hFFFF_FC00;
    localparam logic [31:0] BTN_ADDR_2 = 32'hC000_0000;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } access_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Parameterised synchronous FIFO with drop-on-full.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write request; push_data is stored when accepted
//   pop         - read request; ignored while empty
//   head        - oldest entry, or 0 when empty
//   cnt         - number of stored entries (0..DEPTH)
//   pop_eff     - a pop actually removed an entry this cycle
//   drop        - a push was discarded because the FIFO was full
//
// A push while full is still accepted if an effective pop happens in the
// same cycle, since the pop frees the slot the push lands in.
module sync_fifo #(
    parameter  int WIDTH = 5,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    cnt,
    output logic             pop_eff,
    output logic             drop
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rp;
    logic [AW-1:0]    wp;
    logic [CW-1:0]    cnt_q;
    logic             push_ok;

    assign pop_eff = pop && (cnt_q != '0);
    assign push_ok = push && ((cnt_q != CW'(DEPTH)) || pop_eff);
    assign drop    = push && !push_ok;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp    <= '0;
            wp    <= '0;
            cnt_q <= '0;
        end else begin
            if (pop_eff) begin
                rp <= rp + AW'(1);
            end
            if (push_ok) begin
                wp <= wp + AW'(1);
            end
            if (push_ok && !pop_eff) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (!push_ok && pop_eff) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    // Storage is not reset; cnt alone says which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wp] <= push_data;
        end
    end

    assign head = (cnt_q != '0) ? mem[rp] : '0;
    assign cnt  = cnt_q;

endmodule

// File: rtl/key_input_buffer.sv
// Key input buffer between the keypad scanner and the CPU Button port.
// Queues scanner key codes and removes exactly one code per CPU read access
// to the Button address (either alias), however many cycles the read lasts.
//
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   key_valid     - one-cycle pulse: key_code holds a new code
//   key_code      - scanned key code
//   addr_bus      - CPU address
//   mem_w         - 1 = write, 0 = read
//   key_ready     - buffer holds at least one code
//   Keys          - head code, 0 when empty
//   key_overflow  - sticky: a code was dropped; cleared by the next effective pop
//   key_count     - number of buffered codes
//   access_state  - current access FSM state (debug visibility)
//
// Handshake: the CPU sees Keys/key_ready combinationally during its access;
// the pop happens on the clock edge that ends the first cycle of a read
// access, so the new head appears from the following cycle. Any cycle with
// the read deasserted ends the access; consecutive read cycles with no gap
// form one access.
module key_input_buffer #(
    parameter int          DEPTH      = 8,
    parameter int          KEY_W      = mio_pkg::KEY_W,
    parameter logic [31:0] BTN_ADDR_1 = mio_pkg::BTN_ADDR_1,
    parameter logic [31:0] BTN_ADDR_2 = mio_pkg::BTN_ADDR_2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_valid,
    input  logic [KEY_W-1:0]       key_code,
    input  logic [31:0]            addr_bus,
    input  logic                   mem_w,
    output logic                   key_ready,
    output logic [KEY_W-1:0]       Keys,
    output logic                   key_overflow,
    output logic [$clog2(DEPTH):0] key_count,
    output mio_pkg::access_state_t access_state
);

    mio_pkg::access_state_t state_q;
    mio_pkg::access_state_t state_d;
    logic                   hit;
    logic                   pop;
    logic                   pop_eff;
    logic                   drop;

    assign hit = ((addr_bus == BTN_ADDR_1) || (addr_bus == BTN_ADDR_2)) && !mem_w;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= mio_pkg::IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // pop is a pulse on the IDLE->ACCESS transition only.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            mio_pkg::IDLE: begin
                if (hit) begin
                    state_d = mio_pkg::ACCESS;
                    pop     = 1'b1;
                end
            end
            mio_pkg::ACCESS: begin
                if (!hit) begin
                    state_d = mio_pkg::IDLE;
                end
            end
            default: state_d = mio_pkg::IDLE;
        endcase
    end

    sync_fifo #(
        .WIDTH(KEY_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .push     (key_valid),
        .push_data(key_code),
        .pop      (pop),
        .head     (Keys),
        .cnt      (key_count),
        .pop_eff  (pop_eff),
        .drop     (drop)
    );

    // A drop can only happen without an effective pop, so set and clear
    // never conflict; set is checked first regardless.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_overflow <= 1'b0;
        end else if (drop) begin
            key_overflow <= 1'b1;
        end else if (pop_eff) begin
            key_overflow <= 1'b0;
        end
    end

    assign key_ready    = (key_count != '0);
    assign access_state = state_q;

endmodule

// File: tb/tb_key_input_buffer.sv
module tb_key_input_buffer;

    localparam int          DEPTH = 8;
    localparam logic [31:0] A1    = 32'hFFFF_FC00;
    localparam logic [31:0] A2    = 32'hC000_0000;
    localparam logic [31:0] AX    = 32'h0000_0100;

    logic                   clk;
    logic                   rst;
    logic                   key_valid;
    logic [4:0]             key_code;
    logic [31:0]            addr_bus;
    logic                   mem_w;
    logic                   key_ready;
    logic [4:0]             Keys;
    logic                   key_overflow;
    logic [3:0]             key_count;
    mio_pkg::access_state_t access_state;

    int checks;
    int passes;

    // Reference model: queue of pending codes, sticky overflow, and whether
    // the previous sampled cycle was already a Button read.
    logic [4:0] exp_q[$];
    logic       m_ovf;
    logic       m_prev_hit;

    key_input_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .addr_bus    (addr_bus),
        .mem_w       (mem_w),
        .key_ready   (key_ready),
        .Keys        (Keys),
        .key_overflow(key_overflow),
        .key_count   (key_count),
        .access_state(access_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model_reset();
        exp_q.delete();
        m_ovf      = 1'b0;
        m_prev_hit = 1'b0;
    endfunction

    // {key_ready, Keys, key_count, key_overflow} as the model predicts it.
    function automatic logic [10:0] exp_vec();
        logic [4:0] h;
        h = (exp_q.size() != 0) ? exp_q[0] : 5'd0;
        return {exp_q.size() != 0, h, 4'(exp_q.size()), m_ovf};
    endfunction

    function automatic logic [10:0] obs_vec();
        return {key_ready, Keys, key_count, key_overflow};
    endfunction

    // ---------------- driver ----------------
    // Apply inputs for one clock, advance the model on the edge, and return
    // 1 time unit after the edge so outputs can be sampled.
    task automatic cycle(input logic kv, input logic [4:0] kc,
                         input logic [31:0] a, input logic w);
        logic hit;
        logic pe;
        key_valid = kv;
        key_code  = kc;
        addr_bus  = a;
        mem_w     = w;
        @(posedge clk);
        hit        = ((a == A1) || (a == A2)) && !w;
        pe         = hit && !m_prev_hit && (exp_q.size() != 0);
        m_prev_hit = hit;
        if (pe) begin
            void'(exp_q.pop_front());
            m_ovf = 1'b0;
        end
        if (kv) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(kc);
            else m_ovf = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'h0, 1'b0);
    endtask

    task automatic apply_reset();
        key_valid = 1'b0;
        key_code  = '0;
        addr_bus  = '0;
        mem_w     = 1'b0;
        rst       = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst       = 1'b0;
        key_valid = 1'b0;
        key_code  = '0;
        addr_bus  = A1;
        mem_w     = 1'b0;
        model_reset();
        #2;
        checks++;
        if ({obs_vec(), access_state} !== {11'd0, mio_pkg::IDLE})
            $display("FAIL reset_outputs: got %h/%0d required 0/IDLE", obs_vec(), access_state);
        else passes++;
        @(posedge clk);
        @(posedge clk);
        #1;
        addr_bus = '0;
        rst      = 1'b1;
    endtask

    task automatic test_single_push();
        cycle(1'b1, 5'h0A, 32'h0, 1'b0);
        checks++;
        if ({key_ready, Keys} !== {1'b1, 5'h0A} || obs_vec() !== exp_vec())
            $display("FAIL single_push: got %h required %h", obs_vec(), exp_vec());
        else passes++;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 5'd0, A1, 1'b0);
            checks++;
            if (key_count !== 4'd0 || access_state !== mio_pkg::ACCESS || obs_vec() !== exp_vec())
                $display("FAIL long_read_cycle%0d: got cnt=%0d st=%0d required cnt=0 st=ACCESS",
                         i, key_count, access_state);
            else passes++;
        end
        idle();
        checks++;
        if (access_state !== mio_pkg::IDLE || obs_vec() !== exp_vec())
            $display("FAIL long_read_end: got st=%0d %h required IDLE %h", access_state, obs_vec(), exp_vec());
        else passes++;
    endtask

    task automatic test_ordered_reads();
        logic [4:0] want;
        for (int i = 1; i <= 3; i++) cycle(1'b1, 5'(i), 32'h0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            want = 5'(i);
            checks++;
            if (Keys !== want || key_ready !== 1'b1)
                $display("FAIL ordered_head%0d: got %h required %h", i, Keys, want);
            else passes++;
            cycle(1'b0, 5'd0, A2, 1'b0);
            idle();
        end
        checks++;
        if ({key_ready, Keys} !== 6'd0 || obs_vec() !== exp_vec())
            $display("FAIL ordered_empty: got %h required %h", obs_vec(), exp_vec());
        else passes++;
    endtask

    task automatic test_overflow();
        logic [4:0] last;
        for (int i = 0; i <= DEPTH; i++) cycle(1'b1, 5'(i), 32'h0, 1'b0);
        checks++;
        if ({key_count, key_overflow, Keys} !== {4'd8, 1'b1, 5'h00} || obs_vec() !== exp_vec())
            $display("FAIL overflow_full: got %h required %h", obs_vec(), exp_vec());
        else passes++;
        cycle(1'b0, 5'd0, A1, 1'b0);
        idle();
        checks++;
        if ({key_count, key_overflow, Keys} !== {4'd7, 1'b0, 5'h01} || obs_vec() !== exp_vec())
            $display("FAIL overflow_clear: got %h required %h", obs_vec(), exp_vec());
        else passes++;
        // Refill, then push and pop in the same cycle while full.
        cycle(1'b1, 5'h09, 32'h0, 1'b0);
        cycle(1'b1, 5'h1F, A1, 1'b0);
        checks++;
        if ({key_count, key_overflow} !== {4'd8, 1'b0} || obs_vec() !== exp_vec())
            $display("FAIL full_push_pop: got %h required %h", obs_vec(), exp_vec());
        else passes++;
        idle();
        last = '0;
        for (int i = 0; i < DEPTH; i++) begin
            last = Keys;
            cycle(1'b0, 5'd0, A2, 1'b0);
            idle();
            checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL drain%0d: got %h required %h", i, obs_vec(), exp_vec());
            else passes++;
        end
        checks++;
        if (last !== 5'h1F || key_ready !== 1'b0)
            $display("FAIL drain_last: got %h ready=%0d required 1f ready=0", last, key_ready);
        else passes++;
    endtask

    task automatic test_write_no_pop();
        apply_reset();
        cycle(1'b1, 5'($urandom_range(0, 31)), 32'h0, 1'b0);
        cycle(1'b1, 5'($urandom_range(0, 31)), 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 5'd0, A1, 1'b1);
        checks++;
        if (key_count !== 4'd2 || obs_vec() !== exp_vec())
            $display("FAIL write_no_pop: got cnt=%0d required 2", key_count);
        else passes++;
        cycle(1'b0, 5'd0, AX, 1'b0);
        cycle(1'b0, 5'd0, AX, 1'b0);
        idle();
        checks++;
        if (key_count !== 4'd2 || obs_vec() !== exp_vec())
            $display("FAIL other_addr_no_pop: got cnt=%0d required 2", key_count);
        else passes++;
    endtask

    task automatic test_async_reset();
        logic [4:0] code;
        apply_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 5'($urandom_range(1, 31)), 32'h0, 1'b0);
        addr_bus = A1;
        mem_w    = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({obs_vec(), access_state} !== {11'd0, mio_pkg::IDLE})
            $display("FAIL async_reset: got %h st=%0d required 0 IDLE", obs_vec(), access_state);
        else passes++;
        @(posedge clk);
        #1;
        rst  = 1'b1;
        code = 5'($urandom_range(1, 31));
        cycle(1'b0, 5'd0, A1, 1'b0);
        cycle(1'b1, code, A1, 1'b0);
        cycle(1'b0, 5'd0, A1, 1'b0);
        checks++;
        if ({key_count, Keys} !== {4'd1, code} || obs_vec() !== exp_vec())
            $display("FAIL post_reset_hold: got %h required %h", obs_vec(), exp_vec());
        else passes++;
        idle();
        cycle(1'b0, 5'd0, A1, 1'b0);
        checks++;
        if (key_count !== 4'd0 || obs_vec() !== exp_vec())
            $display("FAIL post_reset_next_read: got %h required %h", obs_vec(), exp_vec());
        else passes++;
        idle();
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          errs;
        errs = 0;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0, 1:    a = A1;
                2:       a = A2;
                3:       a = AX;
                default: a = $urandom;
            endcase
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), a,
                  ($urandom_range(0, 5) == 0));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                if (errs < 10)
                    $display("FAIL random_cycle%0d: got %h required %h", i, obs_vec(), exp_vec());
                errs++;
            end else passes++;
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_single_push();
        test_ordered_reads();
        test_overflow();
        test_write_no_pop();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
